gf64_inv_seq: RTL and testbench

- Folded, multi-cycle GF(2^6) inversion S-box engine for the SMSS32 6-bit S-box family.
- Time-shares one GF(2^3) multiplier across the three tower-field products that the combinational S-box computes in parallel: norm, low output half and high output half.
- An FSM sequences operand selection and intermediate registers; valid/ready handshakes on input and output.
- Sits between the round datapath and the substitution layer in area-constrained builds.

---
 rtl/gf64_inv_seq.sv | 189 ++++++++++++++++++
 tb/tb_gf64_inv_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf64_inv_seq.sv
// Folded GF(2^6) inversion S-box: one GF(2^3) multiplier is time-shared across the
// norm, low-half and high-half products of the tower-field inverse, with valid/ready on both sides.
module gf64_inv_seq #(
  parameter int BYPASS_ISO = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       y,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_NORM = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // GF(2^3) arithmetic, polynomial basis modulo t^3 + t^2 + 1.
  function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
    logic [4:0] d;
    d[0] = a[0] & b[0];
    d[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    d[2] = (a[2] & b[0]) ^ (a[1] & b[1]) ^ (a[0] & b[2]);
    d[3] = (a[2] & b[1]) ^ (a[1] & b[2]);
    d[4] = a[2] & b[2];
    return {d[2] ^ d[3] ^ d[4], d[1] ^ d[4], d[0] ^ d[3] ^ d[4]};
  endfunction

  function automatic logic [2:0] gf8_sq(input logic [2:0] a);
    return {a[1] ^ a[2], a[2], a[0] ^ a[2]};
  endfunction

  // a^6 as a table so no second multiplier is inferred.
  function automatic logic [2:0] gf8_inv(input logic [2:0] a);
    logic [2:0] r;
    case (a)
      3'd1:    r = 3'd1;
      3'd2:    r = 3'd6;
      3'd3:    r = 3'd4;
      3'd4:    r = 3'd3;
      3'd5:    r = 3'd7;
      3'd6:    r = 3'd2;
      3'd7:    r = 3'd5;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] iso(input logic [5:0] v);
    logic [5:0] w;
    w[0] = v[0] ^ v[1] ^ v[2] ^ v[5];
    w[1] = v[1] ^ v[2];
    w[2] = v[1] ^ v[2] ^ v[4];
    w[3] = v[0] ^ v[3];
    w[4] = v[2] ^ v[3] ^ v[4] ^ v[5];
    w[5] = v[1] ^ v[3];
    return w;
  endfunction

  function automatic logic [5:0] inv_iso(input logic [5:0] p);
    logic [5:0] r;
    r[0] = p[0] ^ p[1] ^ p[2] ^ p[4] ^ p[5];
    r[1] = p[0] ^ p[1] ^ p[2] ^ p[3] ^ p[4];
    r[2] = p[0] ^ p[2] ^ p[3] ^ p[4];
    r[3] = p[0] ^ p[1] ^ p[2] ^ p[3] ^ p[4] ^ p[5];
    r[4] = p[1] ^ p[2];
    r[5] = p[2] ^ p[4] ^ p[5];
    return r;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [5:0]       w_q, w_d;
  logic [2:0]       n_q, n_d;
  logic [2:0]       p_lo_q, p_lo_d;
  logic [5:0]       y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic [2:0] lo, hi;
  logic [2:0] mul_a, mul_b, mul_p;
  logic [5:0] x_map, p_full;

  assign lo     = w_q[2:0];
  assign hi     = w_q[5:3];
  assign x_map  = (BYPASS_ISO != 0) ? x : iso(x);
  assign p_full = {mul_p, p_lo_q};

  // The single shared multiplier; only its operands change with state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mul_a = 3'd0;
    mul_b = 3'd0;
    case (state_q)
      S_NORM: begin
        mul_a = lo;
        mul_b = lo ^ hi;
      end
      S_LO: begin
        mul_a = hi;
        mul_b = n_q;
      end
      S_HI: begin
        mul_a = lo;
        mul_b = n_q;
      end
      default: ;
    endcase
  end

  assign mul_p = gf8_mul(mul_a, mul_b);

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    n_d         = n_q;
    p_lo_d      = p_lo_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    done_cnt_d  = done_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          w_d     = x_map;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        n_d     = gf8_inv(gf8_sq(hi) ^ mul_p);
        state_d = S_LO;
      end
      S_LO: begin
        p_lo_d  = mul_p;
        state_d = S_HI;
      end
      S_HI: begin
        y_d         = (BYPASS_ISO != 0) ? p_full : inv_iso(p_full);
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register is reset, intermediates included, so an aborted operation leaves nothing behind.
      state_q     <= S_IDLE;
      w_q         <= '0;
      n_q         <= '0;
      p_lo_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      n_q         <= n_d;
      p_lo_q      <= p_lo_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_gf64_inv_seq.sv
// Bench for gf64_inv_seq: a default instance and a bypass instance with a 2-bit counter,
// checked against a brute-force inverse search in a normal-basis tower-field model.
module tb_gf64_inv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [5:0]  x_a, y_a;
  logic [15:0] done_cnt_a;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [5:0]  x_b, y_b;
  logic [1:0]  done_cnt_b;

  gf64_inv_seq #(.BYPASS_ISO(0), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .x(x_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .y(y_a),
    .busy(busy_a), .done_cnt(done_cnt_a)
  );

  gf64_inv_seq #(.BYPASS_ISO(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .x(x_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .y(y_b),
    .busy(busy_b), .done_cnt(done_cnt_b)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // GF(8) by shift-and-add, reducing t^3 -> t^2 + 1.
  function automatic logic [2:0] f8_mul(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] r;
    logic [2:0] s;
    r = 3'd0;
    s = a;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) r = r ^ s;
      s = s[2] ? ((s << 1) ^ 3'b101) : (s << 1);
    end
    return r;
  endfunction

  // Tower element = lo*z + hi*z' with z' = z+1, z*z' = 1, z^2 = z', z'^2 = z.
  function automatic logic [5:0] tw_mul(input logic [5:0] u, input logic [5:0] v);
    logic [2:0] a, b, c, d, ad, bc;
    a  = u[2:0];
    b  = u[5:3];
    c  = v[2:0];
    d  = v[5:3];
    ad = f8_mul(a, d);
    bc = f8_mul(b, c);
    return {f8_mul(a, c) ^ ad ^ bc, f8_mul(b, d) ^ ad ^ bc};
  endfunction

  localparam logic [5:0] TW_ONE = 6'h09;

  // Standard-to-tower basis change as a sum of matrix columns.
  function automatic logic [5:0] iso_m(input logic [5:0] v);
    logic [5:0] r;
    logic [5:0] col;
    r = 6'd0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: col = 6'h09;
        1: col = 6'h27;
        2: col = 6'h17;
        3: col = 6'h38;
        4: col = 6'h14;
        default: col = 6'h11;
      endcase
      if (v[i]) r = r ^ col;
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_inv(input logic [5:0] v, input bit bypass);
    logic [5:0] wv, wy;
    wv = bypass ? v : iso_m(v);
    if (v == 6'd0) return 6'd0;
    for (int k = 1; k < 64; k++) begin
      wy = bypass ? 6'(k) : iso_m(6'(k));
      if (tw_mul(wv, wy) == TW_ONE) return 6'(k);
    end
    return 6'd0;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Accepts xv and waits for out_valid; lat counts edges from the accept edge inclusive.
  task automatic run_op(input bit sel, input logic [5:0] xv, input bit hold_ready,
                        output logic [5:0] yv, output int lat);
    int guard;
    guard = 0;
    while (!(sel ? in_ready_b : in_ready_a) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_wait", 32'(guard < 20), 32'd1);
    if (sel) begin in_valid_b = 1'b1; x_b = xv; out_ready_b = hold_ready; end
    else     begin in_valid_a = 1'b1; x_a = xv; out_ready_a = hold_ready; end
    @(posedge clk); #1;
    if (sel) begin in_valid_b = 1'b0; x_b = 6'($urandom); end
    else     begin in_valid_a = 1'b0; x_a = 6'($urandom); end
    lat = 1;
    while (!(sel ? out_valid_b : out_valid_a) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (sel) x_b = 6'($urandom); else x_a = 6'($urandom);
    end
    yv = sel ? y_b : y_a;
  endtask

  task automatic handshake(input bit sel);
    if (sel) out_ready_b = 1'b1; else out_ready_a = 1'b1;
    @(posedge clk); #1;
    if (sel) begin out_ready_b = 1'b0; exp_cnt_b++; end
    else     begin out_ready_a = 1'b0; exp_cnt_a++; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] yv, yy, ys, xv;
    int lat;
    int perm[64];
    bit ov_seen;

    rst = 1'b1;
    in_valid_a = 1'b0; x_a = 6'd0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; x_b = 6'd0; out_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state
    check("rst_in_ready",  32'(in_ready_a),  32'd1);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_y",         32'(y_a),         32'd0);
    check("rst_done_cnt",  32'(done_cnt_a),  32'd0);
    check("rst_busy",      32'(busy_a),      32'd0);
    check("rst_b_in_ready", 32'(in_ready_b), 32'd1);

    // x=0 with out_ready held high from the start
    run_op(1'b0, 6'h00, 1'b1, yv, lat);
    check("zero_latency", 32'(lat), 32'd4);
    check("zero_y",       32'(yv),  32'd0);
    handshake(1'b0);
    check("zero_out_valid_clr", 32'(out_valid_a), 32'd0);
    check("zero_done_cnt",      32'(done_cnt_a),  32'(exp_cnt_a));
    check("zero_idle",          32'(in_ready_a),  32'd1);

    // x=1 is its own inverse
    run_op(1'b0, 6'h01, 1'b0, yv, lat);
    check("one_y", 32'(yv), 32'h01);
    handshake(1'b0);

    // All 64 inputs in random order, then feed each result back
    for (int i = 0; i < 64; i++) perm[i] = i;
    for (int i = 63; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 64; i++) begin
      xv = 6'(perm[i]);
      run_op(1'b0, xv, 1'($urandom), yv, lat);
      check("sweep_latency", 32'(lat), 32'd4);
      check($sformatf("sweep_y x=%02h", xv), 32'(yv), 32'(ref_inv(xv, 1'b0)));
      if (xv != 6'd0)
        check($sformatf("sweep_product x=%02h", xv), 32'(tw_mul(iso_m(xv), iso_m(yv))), 32'(TW_ONE));
      handshake(1'b0);
      run_op(1'b0, yv, 1'b0, yy, lat);
      check($sformatf("sweep_involution x=%02h", xv), 32'(yy), 32'(xv));
      handshake(1'b0);
    end
    check("sweep_done_cnt", 32'(done_cnt_a), 32'(exp_cnt_a));

    // Consumer stalls for 10 cycles while new inputs are offered
    run_op(1'b0, 6'h2A, 1'b0, yv, lat);
    ys = yv;
    check("stall_y", 32'(ys), 32'(ref_inv(6'h2A, 1'b0)));
    for (int i = 0; i < 10; i++) begin
      in_valid_a = i[0];
      x_a = 6'($urandom);
      @(posedge clk); #1;
      check("stall_out_valid", 32'(out_valid_a), 32'd1);
      check("stall_y_stable",  32'(y_a),         32'(ys));
      check("stall_in_ready",  32'(in_ready_a),  32'd0);
    end
    in_valid_a = 1'b0;
    check("stall_done_cnt_hold", 32'(done_cnt_a), 32'(exp_cnt_a));
    handshake(1'b0);
    check("stall_release_out_valid", 32'(out_valid_a), 32'd0);
    check("stall_release_idle",      32'(in_ready_a),  32'd1);
    check("stall_release_done_cnt",  32'(done_cnt_a),  32'(exp_cnt_a));
    check("stall_y_retained",        32'(y_a),         32'(ys));
    @(posedge clk); #1;
    check("stall_stays_idle", 32'(busy_a), 32'd0);

    // Asynchronous reset while in LO aborts the operation
    in_valid_a = 1'b1; x_a = 6'h15;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_before", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid_a), 32'd0);
    check("abort_busy",      32'(busy_a),      32'd0);
    check("abort_in_ready",  32'(in_ready_a),  32'd1);
    check("abort_done_cnt",  32'(done_cnt_a),  32'd0);
    check("abort_y",         32'(y_a),         32'd0);
    #1 rst = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    ov_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid_a) ov_seen = 1'b1;
    end
    check("abort_no_result", 32'(ov_seen), 32'd0);
    run_op(1'b0, 6'h15, 1'b0, yv, lat);
    check("abort_next_y", 32'(yv), 32'(ref_inv(6'h15, 1'b0)));
    handshake(1'b0);
    check("abort_next_done_cnt", 32'(done_cnt_a), 32'(exp_cnt_a));

    // Bypass instance: tower-basis in/out, 2-bit counter wraps after 4
    run_op(1'b1, 6'h09, 1'b0, yv, lat);
    check("bypass_one", 32'(yv), 32'h09);
    handshake(1'b1);
    for (int i = 0; i < 4; i++) begin
      xv = 6'($urandom);
      run_op(1'b1, xv, 1'b0, yv, lat);
      check($sformatf("bypass_y x=%02h", xv), 32'(yv), 32'(ref_inv(xv, 1'b1)));
      handshake(1'b1);
    end
    check("bypass_done_cnt_wrap", 32'(done_cnt_b), 32'(exp_cnt_b % 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
